// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between NUM_REQ requesters. A requester
//   offers (operand_a, operand_b, opcode) on a valid/ready handshake. The
//   arbiter grants one of them, registers its operands onto the ALU inputs,
//   captures result/zero one cycle later and then holds the response for the
//   owning requester until that requester accepts it.
//
//   Sequence: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (held response).
//
//   Configuration macro:
//     ALU_ARB_FIXED_PRIO_EN  defined   : fixed priority, lowest index wins
//                            undefined : round-robin, starvation-free (default)
//
// Ports
//   clk, reset                   clock (rising edge), async active-high reset
//   req_valid/req_ready          per-requester request handshake
//   req_operand_a/_b, req_control packed per-requester operands and opcode
//   rsp_valid/rsp_ready          per-requester response handshake
//   rsp_result, rsp_zero         captured ALU outputs, held during RESP
//   alu_operand_a/_b, alu_control registered ALU inputs
//   alu_result, alu_zero         ALU outputs
//   busy                         high while an operation is in flight
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b,
  input  logic [NUM_REQ*CTRL_WIDTH-1:0] req_control,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_zero,
  output logic [DATA_WIDTH-1:0]         alu_operand_a,
  output logic [DATA_WIDTH-1:0]         alu_operand_b,
  output logic [CTRL_WIDTH-1:0]         alu_control,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_zero,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   owner;
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [CTRL_WIDTH-1:0] sel_ctrl;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last (winning) write.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;

  // Search starts just after the last winner; scanning the offsets from far
  // to near lets the nearest valid requester overwrite the others.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (accept) begin
      rr_ptr <= grant_idx;
    end
  end
`endif

  assign accept = (state == IDLE) && grant_vld;

  // Operand mux for the granted requester.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a    = req_operand_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b    = req_operand_b[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ctrl = req_control[i*CTRL_WIDTH +: CTRL_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= grant_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so req_ready reads zero while reset is held.
        if (grant_vld && !reset) begin
          req_ready = NUM_REQ'(1) << grant_idx;
        end
        if (grant_vld) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = NUM_REQ'(1) << owner;
        // Only the owner's rsp_ready completes the response; no new grant
        // is issued in this cycle even when it completes.
        if (rsp_ready[owner]) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU input registers and response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_control   <= '0;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
    end else begin
      if (accept) begin
        alu_operand_a <= sel_a;
        alu_operand_b <= sel_b;
        alu_control   <= sel_ctrl;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
    end
  end

endmodule
